// File: rtl/rx_bit_sequencer_if.sv
// Receive-side bus between the bit sequencer and its consumer.
//   serial_in      : synchronized serial line (idles high), into the sequencer
//   data_read      : consumer acknowledge, into the sequencer
//   rx_data        : last good received word
//   data_ready     : a new word is held in rx_data
//   framing_error  : sticky, last frame had a bad stop bit
//   overrun_error  : sticky, a word completed while data_ready was already set
//   busy           : sequencer is inside a frame
interface rx_bit_sequencer_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 serial_in;
  logic                 data_read;
  logic [DATA_BITS-1:0] rx_data;
  logic                 data_ready;
  logic                 framing_error;
  logic                 overrun_error;
  logic                 busy;

  // Sequencer side.
  modport master (
    input  serial_in,
    input  data_read,
    output rx_data,
    output data_ready,
    output framing_error,
    output overrun_error,
    output busy
  );

  // Line driver / consumer side.
  modport slave (
    output serial_in,
    output data_read,
    input  rx_data,
    input  data_ready,
    input  framing_error,
    input  overrun_error,
    input  busy
  );
endinterface

// File: rtl/rx_bit_sequencer.sv
// Serial receive sequencer for start/data/stop frames, LSB first.
// It detects the start bit, confirms it at mid-bit, samples each data bit at
// mid-period, checks the stop bit, and presents the word with status flags.
//   clk    : system clock
//   n_rst  : asynchronous active-low reset
//   bus    : rx_bit_sequencer_if.master (serial_in, data_read in;
//            rx_data, data_ready, framing_error, overrun_error, busy out)
module rx_bit_sequencer #(
  parameter int unsigned CLKS_PER_BIT = 10,
  parameter int unsigned DATA_BITS    = 8
) (
  input  logic               clk,
  input  logic               n_rst,
  rx_bit_sequencer_if.master bus
);

  localparam int unsigned TIMER_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned CNT_W   = $clog2(DATA_BITS + 1);
  localparam int unsigned HALF    = CLKS_PER_BIT / 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t               state;
  logic [TIMER_W-1:0]   timer;
  logic [CNT_W-1:0]     bit_cnt;
  logic                 line_prev;
  logic [DATA_BITS-1:0] shift_reg;

  logic start_edge_c;
  logic half_hit_c;
  logic period_hit_c;
  logic last_bit_c;

  // Falling edge of the line; needs a high sample first, so a line held low
  // after a glitch or bad stop bit cannot retrigger.
  assign start_edge_c = line_prev & ~bus.serial_in;
  // Timer counts the edges since the last reference point, minus one.
  assign half_hit_c   = (timer == TIMER_W'(HALF - 1));
  assign period_hit_c = (timer == TIMER_W'(CLKS_PER_BIT - 1));
  assign last_bit_c   = (bit_cnt == CNT_W'(DATA_BITS - 1));

  // Control FSM, bit-period timer, bit counter and registered status.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state             <= IDLE;
      timer             <= '0;
      bit_cnt           <= '0;
      line_prev         <= 1'b1;
      shift_reg         <= '0;
      bus.rx_data       <= '0;
      bus.data_ready    <= 1'b0;
      bus.framing_error <= 1'b0;
      bus.overrun_error <= 1'b0;
      bus.busy          <= 1'b0;
    end else begin
      line_prev <= bus.serial_in;

      // Acknowledge; a word completing on this same edge overrides below.
      if (bus.data_read) begin
        bus.data_ready    <= 1'b0;
        bus.overrun_error <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start_edge_c) begin
            state             <= START;
            timer             <= '0;
            bus.framing_error <= 1'b0;
            bus.busy          <= 1'b1;
          end
        end

        START: begin
          if (half_hit_c) begin
            timer <= '0;
            if (!bus.serial_in) begin
              state   <= DATA;
              bit_cnt <= '0;
            end else begin
              // Start bit did not hold to mid-bit: treat as a glitch.
              state    <= IDLE;
              bus.busy <= 1'b0;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end

        DATA: begin
          if (period_hit_c) begin
            timer <= '0;
            // Shift in from the top so the first bit ends up in bit 0.
            shift_reg <= {bus.serial_in, shift_reg[DATA_BITS-1:1]};
            bit_cnt   <= bit_cnt + 1'b1;
            if (last_bit_c) begin
              state <= STOP;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end

        STOP: begin
          if (period_hit_c) begin
            timer    <= '0;
            bit_cnt  <= '0;
            state    <= IDLE;
            bus.busy <= 1'b0;
            if (bus.serial_in) begin
              bus.rx_data    <= shift_reg;
              bus.data_ready <= 1'b1;
              if (bus.data_ready && !bus.data_read) begin
                bus.overrun_error <= 1'b1;
              end
            end else begin
              bus.framing_error <= 1'b1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end

        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx_bit_sequencer.sv
// Self-checking bench for rx_bit_sequencer (CLKS_PER_BIT=10, DATA_BITS=8).
// Expected status comes from a frame-level model: each frame either delivers
// a word or flags a framing error at its stop sample, 95 edges after start.
module tb_rx_bit_sequencer;

  localparam int unsigned CPB = 10;
  localparam int unsigned DB  = 8;

  logic clk;
  logic n_rst;

  rx_bit_sequencer_if #(.DATA_BITS(DB)) bus ();

  rx_bit_sequencer #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (DB)
  ) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Frame-level reference model state.
  logic [7:0] exp_data;
  logic       exp_ready;
  logic       exp_fe;
  logic       exp_ov;
  logic       exp_busy;

  function automatic logic [11:0] exp_vec();
    return {exp_data, exp_ready, exp_fe, exp_ov, exp_busy};
  endfunction

  function automatic logic [11:0] obs_vec();
    return {bus.rx_data, bus.data_ready, bus.framing_error, bus.overrun_error, bus.busy};
  endfunction

  task automatic model_reset();
    exp_data = 8'h00; exp_ready = 1'b0; exp_fe = 1'b0; exp_ov = 1'b0; exp_busy = 1'b0;
  endtask

  task automatic model_start();
    exp_fe   = 1'b0;
    exp_busy = 1'b1;
  endtask

  task automatic model_stop(input logic [7:0] d, input logic sb, input logic rd);
    exp_busy = 1'b0;
    if (sb) begin
      if (rd)             exp_ov = 1'b0;
      else if (exp_ready) exp_ov = 1'b1;
      exp_ready = 1'b1;
      exp_data  = d;
    end else begin
      exp_fe = 1'b1;
      if (rd) begin
        exp_ready = 1'b0;
        exp_ov    = 1'b0;
      end
    end
  endtask

  task automatic model_read();
    exp_ready = 1'b0;
    exp_ov    = 1'b0;
  endtask

  // One clock edge, then settle; outputs are observed here, inputs driven here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a frame up to (not including) the stop sample edge t+95.
  task automatic send_frame(input logic [7:0] d, input logic sb);
    logic [9:0] bits;
    bits = {sb, d, 1'b0};
    for (int i = 0; i < 95; i++) begin
      bus.serial_in = bits[i / 10];
      step();
      if (i == 0) model_start();
    end
  endtask

  // Stop sample edge, with data_read optionally coincident.
  task automatic finish_frame(input logic rd);
    bus.data_read = rd;
    step();
    bus.data_read = 1'b0;
  endtask

  task automatic pulse_read();
    bus.data_read = 1'b1;
    step();
    bus.data_read = 1'b0;
    model_read();
  endtask

  task automatic idle(input int n);
    bus.serial_in = 1'b1;
    repeat (n) step();
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    bus.serial_in = 1'b1;
    bus.data_read = 1'b0;
    model_reset();
    #12;
    n_checks++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_values: observed %h expected %h", obs_vec(), exp_vec());
    end
    step();
    n_rst = 1'b1;
    idle(3);
  endtask

  task automatic test_frame_a5();
    idle(5);
    send_frame(8'hA5, 1'b1);
    n_checks++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL a5_before_stop: observed %h expected %h", obs_vec(), exp_vec());
    end
    finish_frame(1'b0);
    model_stop(8'hA5, 1'b1, 1'b0);
    n_checks++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL a5_done: observed %h expected %h", obs_vec(), exp_vec());
    end
    idle(4);
    pulse_read();
    n_checks++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL a5_read_clear: observed %h expected %h", obs_vec(), exp_vec());
    end
    idle(3);
  endtask

  task automatic test_glitch();
    bus.serial_in = 1'b0;
    step();
    model_start();
    step();
    step();
    bus.serial_in = 1'b1;
    step();
    step();
    n_checks++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL glitch_busy_t4: observed %h expected %h", obs_vec(), exp_vec());
    end
    step();
    exp_busy = 1'b0;
    n_checks++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL glitch_reject_t5: observed %h expected %h", obs_vec(), exp_vec());
    end
    idle(5);
  endtask

  task automatic test_framing();
    send_frame(8'h3C, 1'b0);
    finish_frame(1'b0);
    model_stop(8'h3C, 1'b0, 1'b0);
    n_checks++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL framing_flag: observed %h expected %h", obs_vec(), exp_vec());
    end
    for (int i = 0; i < 30; i++) begin
      step();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL framing_low_hold cycle %0d: observed %h expected %h", i, obs_vec(), exp_vec());
      end
    end
    idle(2);
    send_frame(8'h96, 1'b1);
    n_checks++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL framing_cleared_by_start: observed %h expected %h", obs_vec(), exp_vec());
    end
    finish_frame(1'b0);
    model_stop(8'h96, 1'b1, 1'b0);
    n_checks++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL framing_next_frame: observed %h expected %h", obs_vec(), exp_vec());
    end
    idle(3);
  endtask

  task automatic test_back_to_back_overrun();
    pulse_read();
    idle(2);
    send_frame(8'h11, 1'b1);
    finish_frame(1'b0);
    model_stop(8'h11, 1'b1, 1'b0);
    n_checks++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL b2b_first: observed %h expected %h", obs_vec(), exp_vec());
    end
    // Start bit begins on the very next edge after the stop sample.
    send_frame(8'h22, 1'b1);
    finish_frame(1'b0);
    model_stop(8'h22, 1'b1, 1'b0);
    n_checks++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL b2b_overrun: observed %h expected %h", obs_vec(), exp_vec());
    end
    idle(4);
    pulse_read();
    n_checks++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL overrun_read_clear: observed %h expected %h", obs_vec(), exp_vec());
    end
    idle(2);
  endtask

  task automatic test_read_at_stop();
    send_frame(8'h11, 1'b1);
    finish_frame(1'b0);
    model_stop(8'h11, 1'b1, 1'b0);
    idle(5);
    send_frame(8'h22, 1'b1);
    finish_frame(1'b1);
    model_stop(8'h22, 1'b1, 1'b1);
    n_checks++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL read_at_stop: observed %h expected %h", obs_vec(), exp_vec());
    end
    idle(3);
  endtask

  task automatic test_reset_mid_frame();
    logic [9:0] bits;
    bits = {1'b1, 8'h77, 1'b0};
    for (int i = 0; i < 40; i++) begin
      bus.serial_in = bits[i / 10];
      step();
      if (i == 0) model_start();
    end
    n_rst = 1'b0;
    bus.serial_in = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_mid_async: observed %h expected %h", obs_vec(), exp_vec());
    end
    repeat (5) step();
    n_rst = 1'b1;
    idle(3);
    n_checks++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_mid_release: observed %h expected %h", obs_vec(), exp_vec());
    end
    send_frame(8'h5A, 1'b1);
    finish_frame(1'b0);
    model_stop(8'h5A, 1'b1, 1'b0);
    n_checks++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_mid_next_frame: observed %h expected %h", obs_vec(), exp_vec());
    end
    idle(3);
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic       sb;
    logic       rd;
    int         gap;
    for (int f = 0; f < 24; f++) begin
      d  = 8'($urandom);
      sb = ($urandom_range(0, 3) != 0);
      rd = ($urandom_range(0, 2) == 0);
      send_frame(d, sb);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random_pre_stop frame %0d: observed %h expected %h", f, obs_vec(), exp_vec());
      end
      finish_frame(rd);
      model_stop(d, sb, rd);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random_stop frame %0d data %h: observed %h expected %h", f, d, obs_vec(), exp_vec());
      end
      if ($urandom_range(0, 1) == 1) begin
        pulse_read();
        n_checks++;
        if (obs_vec() !== exp_vec()) begin
          n_fail++;
          $display("FAIL random_read frame %0d: observed %h expected %h", f, obs_vec(), exp_vec());
        end
      end
      // A line left low by a bad stop bit must go high before the next start.
      gap = sb ? $urandom_range(0, 3) : $urandom_range(1, 3);
      idle(gap);
    end
  endtask

  initial begin
    n_rst = 1'b0;
    bus.serial_in = 1'b1;
    bus.data_read = 1'b0;
    model_reset();
    test_reset();
    test_frame_a5();
    test_glitch();
    test_framing();
    test_back_to_back_overrun();
    test_read_at_stop();
    test_reset_mid_frame();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_bit_sequencer.md
Name: rx_bit_sequencer

Overview:
- Serial receive sequencer for 8N1-style frames, built from the counters in our flex-counter family: a bit-period timer and a bit counter, plus a control FSM.
- Sits directly downstream of the input synchronizer and upstream of the receive FIFO/register interface.
- Detects the start bit, samples each data bit at mid-period, checks the stop bit, and presents a parallel byte with ready/error status.

Parameters:
- CLKS_PER_BIT, 10, clk cycles per serial bit; legal range 4..1023.
- DATA_BITS, 8, data bits per frame, sent LSB first; legal range 5..9.

Ports:
- clk  input  1  system clock.
- n_rst  input  1  reset, asynchronous, active-low.
- serial_in  input  1  already-synchronized serial line; idles high.
- data_read  input  1  consumer acknowledge; clears data_ready and overrun_error.
- rx_data  output  DATA_BITS  last good received byte.
- data_ready  output  1  level; a new byte is held in rx_data.
- framing_error  output  1  sticky; the last frame had a bad stop bit.
- overrun_error  output  1  sticky; a byte completed while data_ready was already 1.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset values: rx_data=0, data_ready=0, framing_error=0, overrun_error=0, busy=0. FSM=IDLE, timer=0, bit counter=0, line_prev=1.
- Internal widths:
  - Timer: $clog2(CLKS_PER_BIT) bits.
  - Bit counter: $clog2(DATA_BITS+1) bits.
  - HALF = CLKS_PER_BIT/2, integer division.
- line_prev is a register of serial_in. A start edge is line_prev==1 && serial_in==0, sampled at clock edge t.
- FSM states: IDLE, START, DATA, STOP.
- IDLE -> START on a start edge at t:
  - Timer cleared.
  - framing_error cleared.
- START: timer increments each cycle. At edge t+HALF, sample serial_in:
  - 0 -> go to DATA; timer and bit counter cleared.
  - 1 -> glitch; return to IDLE with no status change.
- DATA:
  - Bit k (k=0..DATA_BITS-1) is sampled at edge t+HALF+(k+1)*CLKS_PER_BIT.
  - Each sample is shifted into bit k of the internal shift register (LSB first).
  - After the last bit, go to STOP.
- STOP: sample at edge t+HALF+(DATA_BITS+1)*CLKS_PER_BIT.
  - Stop bit = 1:
    - Load rx_data with the shift register.
    - Set data_ready=1.
    - If data_ready was already 1 and data_read is not high in that same cycle, set overrun_error=1.
    - rx_data is overwritten in either case.
  - Stop bit = 0:
    - Set framing_error=1.
    - rx_data and data_ready are unchanged.
  - Either way, return to IDLE at that edge.
- Output timing: all outputs are registered. Status becomes visible right after the sample edge that sets it.
- data_read:
  - data_read=1 at an edge with no byte completing -> data_ready=0 and overrun_error=0 after that edge.
  - data_read coincides with a byte completing -> the new byte wins: data_ready stays 1, rx_data is updated, no overrun is flagged.
- Line held low after a glitch or framing error: no retrigger until serial_in returns high. Falling-edge detection requires line_prev==1.
- Start edges seen while busy are ignored.
- Reset mid-frame: all state returns to reset values immediately (asynchronous). A partial frame is discarded.
- Back-to-back frames: a start edge at the edge immediately after the STOP sample is accepted.

Test Plan:
- Defaults; idle high, then frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1), each bit held 10 cycles, start edge at t -> data_ready=1 from edge t+95; rx_data=0xA5; busy=0 after t+95; no errors.
- 3-cycle low glitch on the idle line -> START rejects it at t+5; busy drops; data_ready=0, rx_data unchanged.
- Frame 0x3C with stop bit 0 -> framing_error=1 at t+95; data_ready stays 0; rx_data keeps its previous value. The line stays low 30 more cycles -> no new frame starts. The next valid frame clears framing_error at its start edge.
- Two frames 0x11 then 0x22, no data_read -> after the second frame rx_data=0x22, data_ready=1, overrun_error=1. Pulse data_read -> both flags are 0 next cycle.
- data_read pulsed on exactly the STOP sample edge of the second frame -> data_ready=1, rx_data=0x22, overrun_error=0.
- n_rst asserted at t+40 mid-frame, released at t+45, line idles high -> all outputs 0 and busy=0 immediately. A following frame 0x5A is received correctly.
